// File: rtl/imem_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_access_arbiter_if
//   Bundles the fetch-stage, program-loader and instruction-memory signals
//   that meet at the instruction memory arbiter.
//
//   Modports:
//     slave  - the arbiter itself (takes requests, drives grants and memory)
//     master - the surrounding system (fetch stage, loader, memory model)
//
//   Signals:
//     fetch_req/fetch_addr         fetch read request and PC
//     fetch_valid/fetch_data       read data returned one cycle after grant
//     cpu_stall                    CPU must hold PC/pipeline this cycle
//     ld_req/ld_addr/ld_data       loader write request
//     ld_ack                       loader write accepted this cycle
//     ld_done                      loader signals end of boot image
//     boot_done                    boot load complete, CPU running
//     mem_en/mem_we/mem_addr/
//     mem_wdata/mem_rdata          single-port synchronous-read memory port
// ----------------------------------------------------------------------------
interface imem_access_arbiter_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   fetch_req;
    logic [PC_WIDTH-1:0]    fetch_addr;
    logic                   fetch_valid;
    logic [INSTR_WIDTH-1:0] fetch_data;
    logic                   cpu_stall;
    logic                   ld_req;
    logic [PC_WIDTH-1:0]    ld_addr;
    logic [INSTR_WIDTH-1:0] ld_data;
    logic                   ld_ack;
    logic                   ld_done;
    logic                   boot_done;
    logic                   mem_en;
    logic                   mem_we;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, ld_done, mem_rdata,
        output fetch_valid, fetch_data, cpu_stall, ld_ack, boot_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, ld_done, mem_rdata,
        input  fetch_valid, fetch_data, cpu_stall, ld_ack, boot_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_access_arbiter.sv
// ----------------------------------------------------------------------------
// imem_access_arbiter
//   Shares the single-port, synchronous-read instruction memory between the
//   MIPS16 fetch stage and the program loader. During boot the CPU is held
//   stalled and only loader writes reach memory; once the loader signals
//   ld_done the arbiter switches to RUN, where fetch has priority but a
//   starvation guard forces a loader slot after STARVE_LIMIT consecutive
//   fetch wins over a pending loader request.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        imem_access_arbiter_if.slave (fetch, loader, memory port)
//     stall_cnt  (IMEM_ARB_PERF_EN only) RUN cycles with cpu_stall=1, saturating
//     ld_cnt     (IMEM_ARB_PERF_EN only) total ld_ack pulses, saturating
//
//   Optional feature macro: IMEM_ARB_PERF_EN adds the two performance
//   counters above. Without it those ports and counters do not exist.
// ----------------------------------------------------------------------------
module imem_access_arbiter #(
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_access_arbiter_if.slave bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          ld_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arbState_t;

    arbState_t              stateReg, stateNext;
    logic [CNT_W-1:0]       starveCntReg, starveCntNext;
    logic                   fetchValidReg;

    logic                   fetchGrant;
    logic                   ldGrant;
    logic                   cpuStall;
    logic                   memEn;
    logic                   memWe;
    logic [PC_WIDTH-1:0]    memAddr;
    logic [INSTR_WIDTH-1:0] memWdata;

    // ------------------------------------------------------------------
    // Registered state: FSM, starvation counter, read-valid pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg      <= BOOT;
            starveCntReg  <= '0;
            fetchValidReg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            starveCntReg  <= starveCntNext;
            fetchValidReg <= fetchGrant;
        end
    end

    // ------------------------------------------------------------------
    // Grant and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext     = stateReg;
        starveCntNext = starveCntReg;
        fetchGrant    = 1'b0;
        ldGrant       = 1'b0;
        cpuStall      = 1'b0;

        case (stateReg)
            BOOT: begin
                // CPU frozen while the image is loaded; a write in the same
                // cycle as ld_done is still granted.
                cpuStall      = 1'b1;
                ldGrant       = bus.ld_req;
                starveCntNext = '0;
                if (bus.ld_done) begin
                    stateNext = RUN;
                end
            end

            RUN: begin
                // Once the loader has lost STARVE_LIMIT times in a row, it
                // takes the next slot even against a fetch.
                fetchGrant = bus.fetch_req & ~(bus.ld_req & (starveCntReg == LIMIT));
                ldGrant    = bus.ld_req & (~bus.fetch_req | (starveCntReg == LIMIT));
                cpuStall   = bus.fetch_req & ~fetchGrant;

                if (!bus.ld_req || ldGrant) begin
                    starveCntNext = '0;
                end else if (fetchGrant && starveCntReg != LIMIT) begin
                    starveCntNext = starveCntReg + 1'b1;
                end
            end

            default: begin
                stateNext = BOOT;
                cpuStall  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port mux: at most one operation per cycle; idle drives zeros
    // ------------------------------------------------------------------
    always_comb begin
        memEn    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        if (ldGrant) begin
            memEn    = 1'b1;
            memWe    = 1'b1;
            memAddr  = bus.ld_addr;
            memWdata = bus.ld_data;
        end else if (fetchGrant) begin
            memEn    = 1'b1;
            memAddr  = bus.fetch_addr;
        end
    end

    assign bus.mem_en      = memEn;
    assign bus.mem_we      = memWe;
    assign bus.mem_addr    = memAddr;
    assign bus.mem_wdata   = memWdata;
    assign bus.ld_ack      = ldGrant;
    assign bus.cpu_stall   = cpuStall;
    assign bus.boot_done   = (stateReg == RUN);
    assign bus.fetch_valid = fetchValidReg;
    assign bus.fetch_data  = bus.mem_rdata;

`ifdef IMEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [15:0] stallCntReg;
    logic [15:0] ldCntReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntReg <= '0;
            ldCntReg    <= '0;
        end else begin
            if (stateReg == RUN && cpuStall && stallCntReg != 16'hFFFF) begin
                stallCntReg <= stallCntReg + 16'd1;
            end
            if (ldGrant && ldCntReg != 16'hFFFF) begin
                ldCntReg <= ldCntReg + 16'd1;
            end
        end
    end

    assign stall_cnt = stallCntReg;
    assign ld_cnt    = ldCntReg;
`endif

endmodule
